fetch_stage: RTL and testbench

Instruction fetch stage placed directly upstream of the CPU decode/execute logic. It owns the program counter and indexes the instruction ROM array. It buffers fetched words in a 2-entry queue and hands them downstream with a valid/ready handshake. Branch redirects from execute flush the queue, and an optional interlock inserts a NOP after each data-memory instruction.

---
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads the instruction ROM and feeds a 2-entry valid/ready queue.
// Optional NOP insertion after data-memory instructions is enabled by defining FETCH_MEMOP_BUBBLE_EN.
module fetch_stage #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned PC_W  = 7
) (
  input  logic                  dividedClk,
  input  logic                  rst,
  input  logic [DEPTH-1:0][31:0] instMem,
  input  logic                  id_ready,
  input  logic                  br_taken,
  input  logic [PC_W-1:0]       br_target,
  output logic                  if_valid,
  output logic [31:0]           if_instr,
  output logic [PC_W-1:0]       if_pc,
  output logic [PC_W-1:0]       fetch_pc
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t          q_q [2];
  entry_t          push_entry;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            head_q, head_d;
  logic            tail_q, tail_d;
  logic [1:0]      count_q, count_d;
  logic            deq, enq;

`ifdef FETCH_MEMOP_BUBBLE_EN
  logic bubble_pend_q, bubble_pend_d;
  logic is_memop;

  assign is_memop = (instMem[pc_q][31:21] == 11'h5c4) || (instMem[pc_q][31:21] == 11'h5c0);
`endif

  assign if_valid = (count_q != 2'd0);
  assign if_instr = if_valid ? q_q[head_q].instr : '0;
  assign if_pc    = if_valid ? q_q[head_q].pc    : '0;
  assign fetch_pc = pc_q;

  assign deq = if_valid && id_ready;
  assign enq = ((count_q < 2'd2) || deq) && !br_taken;

  always_comb begin
    pc_d       = pc_q;
    head_d     = head_q ^ deq;
    tail_d     = tail_q ^ enq;
    count_d    = count_q + {1'b0, enq} - {1'b0, deq};
    push_entry = '{instr: instMem[pc_q], pc: pc_q};
`ifdef FETCH_MEMOP_BUBBLE_EN
    bubble_pend_d = bubble_pend_q;
`endif
    if (br_taken) begin
      pc_d    = br_target;
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = '0;
`ifdef FETCH_MEMOP_BUBBLE_EN
      bubble_pend_d = 1'b0;
`endif
    end else if (enq) begin
`ifdef FETCH_MEMOP_BUBBLE_EN
      // pc only moved once since the memop was pushed (redirect clears the flag), so its address is pc-1
      if (bubble_pend_q) begin
        push_entry    = '{instr: '0, pc: pc_q - PC_W'(1)};
        bubble_pend_d = 1'b0;
      end else begin
        pc_d          = pc_q + PC_W'(1);
        bubble_pend_d = is_memop;
      end
`else
      pc_d = pc_q + PC_W'(1);
`endif
    end
  end

  always_ff @(posedge dividedClk) begin
    if (rst) begin
      pc_q    <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= '0;
`ifdef FETCH_MEMOP_BUBBLE_EN
      bubble_pend_q <= 1'b0;
`endif
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
`ifdef FETCH_MEMOP_BUBBLE_EN
      bubble_pend_q <= bubble_pend_d;
`endif
    end
  end

  // Queue storage needs no reset: count gates visibility of every slot.
  always_ff @(posedge dividedClk) begin
    if (!rst && enq) begin
      q_q[tail_q] <= push_entry;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, bubble sequence, and randomized run
// against a queue-based reference model.
module tb_fetch_stage;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned PC_W  = 7;
`ifdef FETCH_MEMOP_BUBBLE_EN
  localparam bit BUB = 1'b1;
`else
  localparam bit BUB = 1'b0;
`endif

  logic                   dividedClk = 1'b0;
  logic                   rst;
  logic [DEPTH-1:0][31:0] mem;
  logic                   id_ready;
  logic                   br_taken;
  logic [PC_W-1:0]        br_target;
  logic                   if_valid;
  logic [31:0]            if_instr;
  logic [PC_W-1:0]        if_pc;
  logic [PC_W-1:0]        fetch_pc;

  int errors = 0;
  int checks = 0;

  always #5 dividedClk = ~dividedClk;

  fetch_stage #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .dividedClk(dividedClk),
    .rst       (rst),
    .instMem   (mem),
    .id_ready  (id_ready),
    .br_taken  (br_taken),
    .br_target (br_target),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .fetch_pc  (fetch_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue occupancy must stay within 0..2 (a 2-bit count of 3 means over- or underflow).
  always @(negedge dividedClk) begin
    checks++;
    if (dut.count_q > 2'd2) begin
      errors++;
      $display("FAIL occupancy: got %0d expected <=2", dut.count_q);
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr;
    int unsigned pc;
  } ment_t;

  ment_t       mq[$];
  int unsigned mpc;
  bit          mbub;

  function automatic bit memop(input logic [31:0] w);
    return (w[31:21] == 11'h5c4) || (w[31:21] == 11'h5c0);
  endfunction

  task automatic model_edge(input bit r, input bit rdy, input bit br, input int unsigned tgt);
    ment_t e;
    if (r) begin
      mq.delete(); mpc = 0; mbub = 0;
      return;
    end
    if (mq.size() != 0 && rdy) e = mq.pop_front();
    if (br) begin
      mq.delete(); mpc = tgt; mbub = 0;
      return;
    end
    if (mq.size() < 2) begin
      if (mbub) begin
        e.instr = 32'h0; e.pc = (mpc + DEPTH - 1) % DEPTH;
        mq.push_back(e);
        mbub = 0;
      end else begin
        e.instr = mem[mpc]; e.pc = mpc;
        mq.push_back(e);
        if (BUB && memop(mem[mpc])) mbub = 1;
        mpc = (mpc + 1) % DEPTH;
      end
    end
  endtask

  task automatic step_model(input bit r, input bit rdy, input bit br, input int unsigned tgt);
    rst = r; id_ready = rdy; br_taken = br; br_target = PC_W'(tgt);
    @(posedge dividedClk);
    model_edge(r, rdy, br, tgt);
    #1;
    chk("rnd_valid", 32'(if_valid), 32'(mq.size() != 0));
    chk("rnd_instr", if_instr, (mq.size() != 0) ? mq[0].instr : 32'h0);
    chk("rnd_pc", 32'(if_pc), (mq.size() != 0) ? mq[0].pc : 0);
    chk("rnd_fetch_pc", 32'(fetch_pc), mpc);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit        r;
    bit        rdy;
    bit        br;
    logic [6:0] tgt;
    bit        v;
    logic [6:0] pc;
    logic [6:0] fpc;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input bit r, input bit rdy, input bit br, input logic [6:0] tgt,
                         input bit v, input logic [6:0] pc, input logic [6:0] fpc);
    vec_t t;
    t.r = r; t.rdy = rdy; t.br = br; t.tgt = tgt; t.v = v; t.pc = pc; t.fpc = fpc;
    tbl.push_back(t);
  endtask

  logic [31:0] bexp_instr[$];
  logic [6:0]  bexp_pc[$];
  logic [6:0]  bexp_fpc[$];

  initial begin
    rst = 1'b1; id_ready = 1'b0; br_taken = 1'b0; br_target = '0;
    for (int unsigned k = 0; k < DEPTH; k++) mem[k] = $urandom;

    // reset held 4 cycles, stream, backpressure at pc 5, redirect to 15, redirect to 126 and wrap
    add_vec(1'b1, 1'b0, 1'b0, 7'd0,   1'b0, 7'd0,   7'd0);
    add_vec(1'b1, 1'b1, 1'b0, 7'd0,   1'b0, 7'd0,   7'd0);
    add_vec(1'b1, 1'b0, 1'b0, 7'd0,   1'b0, 7'd0,   7'd0);
    add_vec(1'b1, 1'b1, 1'b0, 7'd0,   1'b0, 7'd0,   7'd0);
    add_vec(1'b0, 1'b1, 1'b0, 7'd0,   1'b1, 7'd0,   7'd1);
    add_vec(1'b0, 1'b1, 1'b0, 7'd0,   1'b1, 7'd1,   7'd2);
    add_vec(1'b0, 1'b1, 1'b0, 7'd0,   1'b1, 7'd2,   7'd3);
    add_vec(1'b0, 1'b1, 1'b0, 7'd0,   1'b1, 7'd3,   7'd4);
    add_vec(1'b0, 1'b1, 1'b0, 7'd0,   1'b1, 7'd4,   7'd5);
    add_vec(1'b0, 1'b1, 1'b0, 7'd0,   1'b1, 7'd5,   7'd6);
    add_vec(1'b0, 1'b0, 1'b0, 7'd0,   1'b1, 7'd5,   7'd7);
    add_vec(1'b0, 1'b0, 1'b0, 7'd0,   1'b1, 7'd5,   7'd7);
    add_vec(1'b0, 1'b0, 1'b0, 7'd0,   1'b1, 7'd5,   7'd7);
    add_vec(1'b0, 1'b0, 1'b0, 7'd0,   1'b1, 7'd5,   7'd7);
    add_vec(1'b0, 1'b1, 1'b0, 7'd0,   1'b1, 7'd6,   7'd8);
    add_vec(1'b0, 1'b1, 1'b0, 7'd0,   1'b1, 7'd7,   7'd9);
    add_vec(1'b0, 1'b1, 1'b0, 7'd0,   1'b1, 7'd8,   7'd10);
    add_vec(1'b0, 1'b0, 1'b1, 7'd15,  1'b0, 7'd0,   7'd15);
    add_vec(1'b0, 1'b1, 1'b0, 7'd0,   1'b1, 7'd15,  7'd16);
    add_vec(1'b0, 1'b1, 1'b1, 7'd126, 1'b0, 7'd0,   7'd126);
    add_vec(1'b0, 1'b1, 1'b0, 7'd0,   1'b1, 7'd126, 7'd127);
    add_vec(1'b0, 1'b1, 1'b0, 7'd0,   1'b1, 7'd127, 7'd0);
    add_vec(1'b0, 1'b1, 1'b0, 7'd0,   1'b1, 7'd0,   7'd1);
    add_vec(1'b0, 1'b1, 1'b0, 7'd0,   1'b1, 7'd1,   7'd2);
    add_vec(1'b1, 1'b1, 1'b0, 7'd0,   1'b0, 7'd0,   7'd0);

    // arbitrary ROM contents during the first reset cycles, then the k+1 pattern
    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 2) for (int unsigned k = 0; k < DEPTH; k++) mem[k] = k + 1;
      rst = tbl[i].r; id_ready = tbl[i].rdy; br_taken = tbl[i].br; br_target = tbl[i].tgt;
      @(posedge dividedClk);
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d_pc", i), 32'(if_pc), 32'(tbl[i].pc));
      chk($sformatf("vec%0d_instr", i), if_instr, tbl[i].v ? 32'(tbl[i].pc) + 32'd1 : 32'h0);
      chk($sformatf("vec%0d_fetch_pc", i), 32'(fetch_pc), 32'(tbl[i].fpc));
    end

    // memop bubble sequence
    mem[0] = 32'h11111111; mem[1] = 32'hb88013e0; mem[2] = 32'hcb010003; mem[3] = 32'h22222222;
    bexp_pc.push_back(7'd0); bexp_instr.push_back(32'h11111111); bexp_fpc.push_back(7'd1);
    bexp_pc.push_back(7'd1); bexp_instr.push_back(32'hb88013e0); bexp_fpc.push_back(7'd2);
    if (BUB) begin
      bexp_pc.push_back(7'd1); bexp_instr.push_back(32'h0); bexp_fpc.push_back(7'd2);
    end
    bexp_pc.push_back(7'd2); bexp_instr.push_back(32'hcb010003); bexp_fpc.push_back(7'd3);
    rst = 1'b1; id_ready = 1'b1; br_taken = 1'b0;
    @(posedge dividedClk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < bexp_pc.size(); i++) begin
      @(posedge dividedClk);
      #1;
      chk($sformatf("bub%0d_valid", i), 32'(if_valid), 32'd1);
      chk($sformatf("bub%0d_pc", i), 32'(if_pc), 32'(bexp_pc[i]));
      chk($sformatf("bub%0d_instr", i), if_instr, bexp_instr[i]);
      chk($sformatf("bub%0d_fetch_pc", i), 32'(fetch_pc), 32'(bexp_fpc[i]));
    end

    // randomized run against the reference model
    for (int unsigned k = 0; k < DEPTH; k++) begin
      mem[k] = $urandom;
      if ($urandom_range(0, 3) == 0) mem[k][31:21] = ($urandom_range(0, 1) == 0) ? 11'h5c4 : 11'h5c0;
    end
    step_model(1'b1, 1'b0, 1'b0, 0);
    step_model(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3000; i++) begin
      step_model($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 15) == 0, $urandom_range(0, DEPTH - 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
